// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron front end.
package snn_pkg;

  localparam int unsigned CUR_W = 8;
  localparam int unsigned W_W   = 8;
  localparam logic [CUR_W-1:0] CUR_MAX = 8'd255;

  typedef enum logic {
    SYN_RUN,
    SYN_LOAD
  } syn_state_t;

endpackage

// File: rtl/syn_weight_bank.sv
// Synaptic weight registers with an auto-incrementing byte loader.
module syn_weight_bank
  import snn_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_we,
  input  logic [W_W-1:0]        i_data,
  output logic [N_IN*W_W-1:0]   o_weights,
  output logic                  o_last
);

  localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [AW-1:0]        r_addr;
  logic [N_IN*W_W-1:0]  r_weights;

  assign o_last    = (r_addr == AW'(N_IN - 1));
  assign o_weights = r_weights;

  // Load address restarts on a new load; each accepted beat writes one weight and advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_weights <= '0;
    end else if (i_start) begin
      r_addr <= '0;
    end else if (i_we) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (r_addr == AW'(i)) begin
          r_weights[i*W_W +: W_W] <= i_data;
        end
      end
      // Wrap explicitly so non-power-of-two N_IN never leaves the valid range.
      r_addr <= o_last ? '0 : r_addr + AW'(1);
    end
  end

endmodule

// File: rtl/spike_synapse.sv
// Synaptic front end: weighted spike sum into a decaying, saturating 8-bit current.
module spike_synapse
  import snn_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned DECAY_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   i_spikes,
  input  logic              i_cfg_start,
  input  logic              i_cfg_valid,
  input  logic [W_W-1:0]    i_cfg_data,
  output logic              o_cfg_ready,
  output logic              o_busy,
  output logic [CUR_W-1:0]  o_current,
  output logic              o_sat,
  output logic              o_dropped
);

  localparam int unsigned SUM_W = W_W + $clog2(N_IN);
  localparam int unsigned NXT_W = SUM_W + 1;

  syn_state_t           r_state;
  syn_state_t           w_state_d;
  logic [CUR_W-1:0]     r_current;
  logic                 r_sat;
  logic                 r_dropped;

  logic                 w_load;
  logic                 w_accept;
  logic                 w_start;
  logic                 w_last;
  logic [N_IN*W_W-1:0]  w_weights;
  logic [SUM_W-1:0]     w_sum;
  logic [CUR_W-1:0]     w_decayed;
  logic [NXT_W-1:0]     w_nxt;
  logic                 w_clip;

  assign w_load   = (r_state == SYN_LOAD);
  assign w_accept = w_load & i_cfg_valid;
  assign w_start  = (r_state == SYN_RUN) & i_cfg_start;

  syn_weight_bank #(
    .N_IN (N_IN)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_we      (w_accept),
    .i_data    (i_cfg_data),
    .o_weights (w_weights),
    .o_last    (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SYN_RUN;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state: enter LOAD on start; leave on the last accepted beat.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      SYN_RUN:  if (i_cfg_start) w_state_d = SYN_LOAD;
      SYN_LOAD: if (w_accept && w_last) w_state_d = SYN_RUN;
      default:  w_state_d = SYN_RUN;
    endcase
  end

  // Weighted spike sum plus decayed current; sum width is wide enough never to overflow.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (i_spikes[i]) begin
        w_sum = w_sum + SUM_W'(w_weights[i*W_W +: W_W]);
      end
    end
    w_decayed = r_current >> DECAY_SHIFT;
    w_nxt     = NXT_W'(w_decayed) + NXT_W'(w_sum);
    w_clip    = (w_nxt > NXT_W'(CUR_MAX));
  end

  // Current integrates in RUN; frozen during LOAD where spikes are only flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_current <= '0;
      r_sat     <= 1'b0;
      r_dropped <= 1'b0;
    end else if (!w_load) begin
      r_current <= w_clip ? CUR_MAX : w_nxt[CUR_W-1:0];
      r_sat     <= w_clip;
    end else begin
      r_sat <= 1'b0;
      if (|i_spikes) r_dropped <= 1'b1;
    end
  end

  assign o_cfg_ready = w_load;
  assign o_busy      = w_load;
  assign o_current   = r_current;
  assign o_sat       = r_sat;
  assign o_dropped   = r_dropped;

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse with a reference-model scoreboard.
module tb_spike_synapse;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_spikes;
  logic       i_cfg_start;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_data;
  logic       o_cfg_ready;
  logic       o_busy;
  logic [7:0] o_current;
  logic       o_sat;
  logic       o_dropped;

  spike_synapse #(
    .N_IN        (4),
    .DECAY_SHIFT (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_spikes    (i_spikes),
    .i_cfg_start (i_cfg_start),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_data  (i_cfg_data),
    .o_cfg_ready (o_cfg_ready),
    .o_busy      (o_busy),
    .o_current   (o_current),
    .o_sat       (o_sat),
    .o_dropped   (o_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cur;
    bit sat;
    bit busy;
    bit drop;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural reference state.
  int m_w[4];
  int m_cur;
  bit m_sat;
  bit m_load;
  bit m_drop;
  int m_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("check %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input logic rst, input logic [3:0] spk, input logic st,
                       input logic vld, input logic [7:0] dat);
    int sum;
    int nxt;
    if (!rst) begin
      foreach (m_w[i]) m_w[i] = 0;
      m_cur = 0; m_sat = 0; m_load = 0; m_drop = 0; m_addr = 0;
    end else if (!m_load) begin
      sum = 0;
      for (int i = 0; i < 4; i++) if (spk[i]) sum += m_w[i];
      nxt   = (m_cur >> 1) + sum;
      m_sat = (nxt > 255);
      m_cur = m_sat ? 255 : nxt;
      if (st) begin
        m_load = 1;
        m_addr = 0;
      end
    end else begin
      m_sat = 0;
      if (spk != 4'h0) m_drop = 1;
      if (vld) begin
        m_w[m_addr] = dat;
        if (m_addr == 3) m_load = 0;
        m_addr++;
      end
    end
  endtask

  // Drive one cycle, queue the model's prediction, then compare after the edge.
  task automatic step(input logic rst, input logic [3:0] spk, input logic st,
                      input logic vld, input logic [7:0] dat);
    exp_t e;
    rst_n = rst; i_spikes = spk; i_cfg_start = st; i_cfg_valid = vld; i_cfg_data = dat;
    model(rst, spk, st, vld, dat);
    e.cur = m_cur; e.sat = m_sat; e.busy = m_load; e.drop = m_drop;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_current", 32'(o_current), 32'(e.cur));
    check("sb_sat", 32'(o_sat), 32'(e.sat));
    check("sb_busy", 32'(o_busy), 32'(e.busy));
    check("sb_ready", 32'(o_cfg_ready), 32'(e.busy));
    check("sb_dropped", 32'(o_dropped), 32'(e.drop));
  endtask

  int exp3[6] = '{20, 10, 5, 2, 1, 0};
  int exp4[9] = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
  bit saw_sat;

  initial begin
    rst_n = 1'b0; i_spikes = '0; i_cfg_start = 0; i_cfg_valid = 0; i_cfg_data = '0;
    @(posedge clk); #1;

    // 1: reset with spikes asserted, then spikes on zero weights.
    step(0, 4'hF, 0, 0, 8'd0);
    step(0, 4'hF, 0, 0, 8'd0);
    check("rst_current", 32'(o_current), 0);
    check("rst_ready", 32'(o_cfg_ready), 0);
    step(1, 4'hF, 0, 0, 8'd0);
    check("zero_w_current", 32'(o_current), 0);

    // 2: load 10,20,30,40 with valid gaps; cfg_start inside LOAD must not restart.
    step(1, 4'h0, 1, 0, 8'd0);
    check("load_ready", 32'(o_cfg_ready), 1);
    step(1, 4'h0, 0, 1, 8'd10);
    step(1, 4'h0, 0, 0, 8'd99);
    step(1, 4'h0, 1, 1, 8'd20);
    step(1, 4'h0, 0, 0, 8'd99);
    step(1, 4'h0, 0, 1, 8'd30);
    check("load_ready_mid", 32'(o_cfg_ready), 1);
    step(1, 4'h0, 0, 1, 8'd40);
    check("load_done_ready", 32'(o_cfg_ready), 0);
    check("load_done_busy", 32'(o_busy), 0);
    step(1, 4'h0, 0, 1, 8'd77);

    // 3: single spike on bit1 then decay.
    step(1, 4'h2, 0, 0, 8'd0);
    check("t3_cur0", 32'(o_current), 32'(exp3[0]));
    for (int k = 1; k < 6; k++) begin
      step(1, 4'h0, 0, 0, 8'd0);
      check("t3_cur", 32'(o_current), 32'(exp3[k]));
    end

    // 4: all spikes held, approach 199 without saturating.
    saw_sat = 0;
    for (int k = 0; k < 9; k++) begin
      step(1, 4'hF, 0, 0, 8'd0);
      check("t4_cur", 32'(o_current), 32'(exp4[k]));
      if (o_sat) saw_sat = 1;
    end
    check("t4_no_sat", 32'(saw_sat), 0);
    for (int k = 0; k < 9; k++) step(1, 4'h0, 0, 0, 8'd0);
    check("t4_decay_zero", 32'(o_current), 0);

    // 5: saturation with weights 200,200,0,0.
    step(1, 4'h0, 1, 0, 8'd0);
    step(1, 4'h0, 0, 1, 8'd200);
    step(1, 4'h0, 0, 1, 8'd200);
    step(1, 4'h0, 0, 1, 8'd0);
    step(1, 4'h0, 0, 1, 8'd0);
    step(1, 4'h3, 0, 0, 8'd0);
    check("t5_cur_max", 32'(o_current), 255);
    check("t5_sat", 32'(o_sat), 1);
    step(1, 4'h0, 0, 0, 8'd0);
    check("t5_cur_after", 32'(o_current), 127);
    check("t5_sat_after", 32'(o_sat), 0);

    // Spike and cfg_start together: spike lands, then LOAD.
    step(1, 4'h1, 1, 0, 8'd0);
    check("t6_spike_start", 32'(o_current), 255);

    // 6: spike during LOAD is dropped and sticky; reset mid-load clears everything.
    step(1, 4'h0, 0, 1, 8'd5);
    step(1, 4'h0, 0, 1, 8'd6);
    step(1, 4'h1, 0, 0, 8'd0);
    check("t6_dropped", 32'(o_dropped), 1);
    check("t6_held", 32'(o_current), 255);
    step(1, 4'h0, 0, 0, 8'd0);
    check("t6_sticky", 32'(o_dropped), 1);
    step(0, 4'h0, 0, 0, 8'd0);
    check("t6_rst_drop", 32'(o_dropped), 0);
    check("t6_rst_busy", 32'(o_busy), 0);
    step(1, 4'hF, 0, 0, 8'd0);
    check("t6_w_cleared", 32'(o_current), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
